// File: rtl/vga_timing_generator.sv
// Raster timing source for 640x480@60: pixel-rate divider, H/V position FSMs, sync and video window.
// Latency: positions and all timing outputs change together on the clk edge after the divider reaches CLK_DIV-1.
// No backpressure: free-running. Optional VGA_FRAME_COUNT_EN adds a 16-bit wrapping frame_count output.
module vga_timing_generator #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_VIS_START = 144,
  parameter int unsigned H_VIS_END   = 783,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_VIS_START = 35,
  parameter int unsigned V_VIS_END   = 514
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] horizontal_actual_position,
  output logic [15:0] vertical_actual_position,
  output logic        pixel_tick,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        frame_start
`ifdef VGA_FRAME_COUNT_EN
  , output logic [15:0] frame_count
`endif
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Phase boundaries: the last position of each phase
  localparam logic [15:0] H_SYNC_LAST = 16'(H_SYNC - 1);
  localparam logic [15:0] H_BP_LAST   = 16'(H_VIS_START - 1);
  localparam logic [15:0] H_ACT_LAST  = 16'(H_VIS_END);
  localparam logic [15:0] H_LAST      = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_SYNC_LAST = 16'(V_SYNC - 1);
  localparam logic [15:0] V_BP_LAST   = 16'(V_VIS_START - 1);
  localparam logic [15:0] V_ACT_LAST  = 16'(V_VIS_END);
  localparam logic [15:0] V_LAST      = 16'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    SYNC        = 2'd0,
    BACK_PORCH  = 2'd1,
    ACTIVE      = 2'd2,
    FRONT_PORCH = 2'd3
  } phase_t;

  logic [DIV_W-1:0] r_div;
  logic             r_tick;
  logic [15:0]      r_h_pos;
  logic [15:0]      r_v_pos;
  phase_t           r_h_state;
  phase_t           r_v_state;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_video_on;
  logic             r_frame_start;

  logic             w_adv;
  logic             w_h_end;
  logic             w_v_end;
  logic             w_v_step;
  logic             w_frame_wrap;
  logic [15:0]      w_h_pos_nxt;
  logic [15:0]      w_v_pos_nxt;
  phase_t           w_h_state_nxt;
  phase_t           w_v_state_nxt;

  assign w_adv        = (r_div == DIV_LAST);
  assign w_h_end      = (r_h_pos == H_LAST);
  assign w_v_end      = (r_v_pos == V_LAST);
  assign w_v_step     = w_adv && w_h_end;
  assign w_frame_wrap = w_v_step && w_v_end;

  // Clock divider: counts 0..CLK_DIV-1; the pixel tick is the registered wrap flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_div  <= w_adv ? '0 : r_div + 1'b1;
      r_tick <= w_adv;
    end
  end

  // Horizontal next column and phase, evaluated only on a pixel advance
  always_comb begin
    w_h_pos_nxt   = r_h_pos;
    w_h_state_nxt = r_h_state;
    if (w_adv) begin
      w_h_pos_nxt = w_h_end ? 16'd0 : r_h_pos + 16'd1;
      case (r_h_state)
        SYNC:        if (r_h_pos == H_SYNC_LAST) w_h_state_nxt = BACK_PORCH;
        BACK_PORCH:  if (r_h_pos == H_BP_LAST)   w_h_state_nxt = ACTIVE;
        ACTIVE:      if (r_h_pos == H_ACT_LAST)  w_h_state_nxt = FRONT_PORCH;
        FRONT_PORCH: if (w_h_end)                w_h_state_nxt = SYNC;
        default:                                 w_h_state_nxt = SYNC;
      endcase
    end
  end

  // Vertical next line and phase, evaluated only when the column wraps
  always_comb begin
    w_v_pos_nxt   = r_v_pos;
    w_v_state_nxt = r_v_state;
    if (w_v_step) begin
      w_v_pos_nxt = w_v_end ? 16'd0 : r_v_pos + 16'd1;
      case (r_v_state)
        SYNC:        if (r_v_pos == V_SYNC_LAST) w_v_state_nxt = BACK_PORCH;
        BACK_PORCH:  if (r_v_pos == V_BP_LAST)   w_v_state_nxt = ACTIVE;
        ACTIVE:      if (r_v_pos == V_ACT_LAST)  w_v_state_nxt = FRONT_PORCH;
        FRONT_PORCH: if (w_v_end)                w_v_state_nxt = SYNC;
        default:                                 w_v_state_nxt = SYNC;
      endcase
    end
  end

  // Position counters and phase state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_pos   <= 16'd0;
      r_v_pos   <= 16'd0;
      r_h_state <= SYNC;
      r_v_state <= SYNC;
    end else begin
      r_h_pos   <= w_h_pos_nxt;
      r_v_pos   <= w_v_pos_nxt;
      r_h_state <= w_h_state_nxt;
      r_v_state <= w_v_state_nxt;
    end
  end

  // Timing outputs decoded from the next phase so they land on the same edge as the positions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_video_on    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame_wrap;
      if (w_adv) begin
        r_hsync    <= (w_h_state_nxt != SYNC);
        r_vsync    <= (w_v_state_nxt != SYNC);
        r_video_on <= (w_h_state_nxt == ACTIVE) && (w_v_state_nxt == ACTIVE);
      end
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] r_frame_cnt;

  // Frame counter bumps on the same edge that raises frame_start; wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= 16'd0;
    end else if (w_frame_wrap) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_count = r_frame_cnt;
`endif

  assign horizontal_actual_position = r_h_pos;
  assign vertical_actual_position   = r_v_pos;
  assign pixel_tick                 = r_tick;
  assign hsync                      = r_hsync;
  assign vsync                      = r_vsync;
  assign video_on                   = r_video_on;
  assign frame_start                = r_frame_start;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: three instances (CLK_DIV=4 and CLK_DIV=1 at 640x480 geometry,
// plus a shrunken raster with CLK_DIV=2 for frame wrap and random async resets), each compared
// every cycle with an arithmetic model of position = elapsed ticks mod frame size.
module tb_vga_timing_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_s;
  logic chk_on;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [15:0] h_a, v_a, h_b, v_b, h_s, v_s;
  logic tick_a, hs_a, vs_a, vo_a, fs_a;
  logic tick_b, hs_b, vs_b, vo_b, fs_b;
  logic tick_s, hs_s, vs_s, vo_s, fs_s;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] fc_a, fc_b, fc_s;
`endif

  vga_timing_generator #(.CLK_DIV(4)) dut_a (
    .clk(clk), .rst_n(rst_a),
    .horizontal_actual_position(h_a), .vertical_actual_position(v_a),
    .pixel_tick(tick_a), .hsync(hs_a), .vsync(vs_a), .video_on(vo_a), .frame_start(fs_a)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(fc_a)
`endif
  );

  vga_timing_generator #(.CLK_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_b),
    .horizontal_actual_position(h_b), .vertical_actual_position(v_b),
    .pixel_tick(tick_b), .hsync(hs_b), .vsync(vs_b), .video_on(vo_b), .frame_start(fs_b)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(fc_b)
`endif
  );

  vga_timing_generator #(
    .CLK_DIV(2), .H_TOTAL(20), .H_SYNC(3), .H_VIS_START(6), .H_VIS_END(15),
    .V_TOTAL(12), .V_SYNC(2), .V_VIS_START(4), .V_VIS_END(9)
  ) dut_s (
    .clk(clk), .rst_n(rst_s),
    .horizontal_actual_position(h_s), .vertical_actual_position(v_s),
    .pixel_tick(tick_s), .hsync(hs_s), .vsync(vs_s), .video_on(vo_s), .frame_start(fs_s)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(fc_s)
`endif
  );

  logic [36:0] o_a, o_b, o_s;
  assign o_a = {h_a, v_a, tick_a, hs_a, vs_a, vo_a, fs_a};
  assign o_b = {h_b, v_b, tick_b, hs_b, vs_b, vo_b, fs_b};
  assign o_s = {h_s, v_s, tick_s, hs_s, vs_s, vo_s, fs_s};

  // Clock edges elapsed since each instance left reset
  int unsigned n_a, n_b, n_s;
  always @(posedge clk or negedge rst_a) if (!rst_a) n_a <= 0; else n_a <= n_a + 1;
  always @(posedge clk or negedge rst_b) if (!rst_b) n_b <= 0; else n_b <= n_b + 1;
  always @(posedge clk or negedge rst_s) if (!rst_s) n_s <= 0; else n_s <= n_s + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: n edges after release -> ticks t = n/d, raster position = t mod (ht*vt)
  function automatic logic [36:0] model(
    input int unsigned n, input int unsigned d,
    input int unsigned ht, input int unsigned hsw, input int unsigned hvs, input int unsigned hve,
    input int unsigned vt, input int unsigned vsw, input int unsigned vvs, input int unsigned vve);
    int unsigned t, p, h, v;
    logic tk, fs, vo;
    t  = n / d;
    p  = t % (ht * vt);
    h  = p % ht;
    v  = p / ht;
    tk = (n != 0) && ((n % d) == 0);
    fs = tk && (p == 0);
    vo = (h >= hvs) && (h <= hve) && (v >= vvs) && (v <= vve);
    return {16'(h), 16'(v), tk, (h >= hsw), (v >= vsw), vo, fs};
  endfunction

  // Cycle-by-cycle comparison of every instance against the model
  always @(negedge clk) begin
    if (chk_on) begin
      check("model_a", 64'(o_a), 64'(model(n_a, 4, 800, 96, 144, 783, 525, 2, 35, 514)));
      check("model_b", 64'(o_b), 64'(model(n_b, 1, 800, 96, 144, 783, 525, 2, 35, 514)));
      check("model_s", 64'(o_s), 64'(model(n_s, 2, 20, 3, 6, 15, 12, 2, 4, 9)));
    end
  end

  typedef struct {
    int unsigned n;
    logic [15:0] h;
    logic [15:0] v;
    logic        hs;
    logic        vs;
    logic        vo;
  } vec_t;

  vec_t tbl [12];

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Expected states of the CLK_DIV=1 instance, indexed by clocks since release
    tbl[0]  = '{1,     16'd1,   16'd0,  1'b0, 1'b0, 1'b0};
    tbl[1]  = '{95,    16'd95,  16'd0,  1'b0, 1'b0, 1'b0};
    tbl[2]  = '{96,    16'd96,  16'd0,  1'b1, 1'b0, 1'b0};
    tbl[3]  = '{799,   16'd799, 16'd0,  1'b1, 1'b0, 1'b0};
    tbl[4]  = '{800,   16'd0,   16'd1,  1'b0, 1'b0, 1'b0};
    tbl[5]  = '{896,   16'd96,  16'd1,  1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1600,  16'd0,   16'd2,  1'b0, 1'b1, 1'b0};
    tbl[7]  = '{27344, 16'd144, 16'd34, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{28143, 16'd143, 16'd35, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{28144, 16'd144, 16'd35, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{28783, 16'd783, 16'd35, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{28784, 16'd784, 16'd35, 1'b1, 1'b1, 1'b0};

    chk_on = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1; rst_s = 1'b1;
    #1;
    rst_a = 1'b0; rst_b = 1'b0; rst_s = 1'b0;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    check("reset_a", 64'(o_a), 64'd0);
    check("reset_b", 64'(o_b), 64'd0);
    check("reset_s", 64'(o_s), 64'd0);
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1; rst_s = 1'b1;

    fork
      begin : branch_b
        int unsigned g;
        for (int i = 0; i < 12; i++) begin
          g = 0;
          while (n_b < tbl[i].n && g < 40000) begin
            @(negedge clk);
            g++;
          end
          check($sformatf("tbl[%0d]", i), 64'(o_b[36:1]),
                64'({tbl[i].h, tbl[i].v, 1'b1, tbl[i].hs, tbl[i].vs, tbl[i].vo}));
        end
        g = 0;
        while (n_b < 29200 && g < 2000) begin
          @(negedge clk);
          g++;
        end
        check("b_pre_rst_pos", 64'({h_b, v_b}), 64'({16'd400, 16'd36}));
        @(posedge clk);
        #2;
        rst_b = 1'b0;
        #1;
        check("b_async_rst", 64'(o_b), 64'd0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        check("b_restart", 64'({h_b, v_b, fs_b}), 64'({16'd1, 16'd0, 1'b0}));
      end

      begin : branch_a
        int unsigned g;
        int unsigned pulses;
        g = 0;
        while (n_a < 3 && g < 100) begin @(negedge clk); g++; end
        check("a_pre_tick", 64'({tick_a, h_a}), 64'({1'b0, 16'd0}));
        @(negedge clk);
        check("a_first_tick", 64'({tick_a, h_a}), 64'({1'b1, 16'd1}));
        @(negedge clk);
        check("a_tick_drop", 64'({tick_a, h_a}), 64'({1'b0, 16'd1}));
        g = 0;
        while (n_a < 3196 && g < 5000) begin @(negedge clk); g++; end
        check("a_799_ticks", 64'({h_a, v_a, hs_a}), 64'({16'd799, 16'd0, 1'b1}));
        repeat (4) @(negedge clk);
        check("a_800_ticks", 64'({h_a, v_a, hs_a, fs_a}), 64'({16'd0, 16'd1, 1'b0, 1'b0}));
        pulses = 0;
        repeat (400) begin
          @(negedge clk);
          if (tick_a) pulses++;
        end
        check("a_tick_rate", 64'(pulses), 64'd100);
      end

      begin : branch_s
        int unsigned pos [3];
        int unsigned nfs;
        for (int r = 0; r < 15; r++) begin
          repeat ($urandom_range(20, 900)) @(negedge clk);
          @(posedge clk);
          #($urandom_range(1, 3));
          rst_s = 1'b0;
          #1;
          check("s_async_rst", 64'(o_s), 64'd0);
          repeat ($urandom_range(1, 4)) @(negedge clk);
          rst_s = 1'b1;
        end
        nfs = 0;
        for (int k = 0; k < 3000 && nfs < 3; k++) begin
          @(negedge clk);
          if (fs_s) begin
            pos[nfs] = n_s;
            nfs++;
`ifdef VGA_FRAME_COUNT_EN
            check("s_frame_count", 64'(fc_s), 64'(nfs));
`endif
          end
        end
        if (nfs < 3) begin
          check("s_frame_timeout", 64'(nfs), 64'd3);
        end else begin
          check("s_frame_first",   64'(pos[0]),          64'd480);
          check("s_frame_period1", 64'(pos[1] - pos[0]), 64'd480);
          check("s_frame_period2", 64'(pos[2] - pos[1]), 64'd480);
        end
`ifdef VGA_FRAME_COUNT_EN
        force dut_s.r_frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut_s.r_frame_cnt;
        nfs = 0;
        for (int k = 0; k < 1000 && nfs < 1; k++) begin
          @(negedge clk);
          if (fs_s) nfs++;
        end
        check("s_frame_count_wrap", 64'({nfs[0], fc_s}), 64'({1'b1, 16'd0}));
`endif
      end
    join

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
- Raster timing source for the 640x480@60 Hz display path.
- Divides the system clock to a pixel-rate tick and runs the horizontal and vertical position counters.
- Drives the VGA hsync/vsync pins.
- Its horizontal_actual_position / vertical_actual_position outputs feed every draw stage directly; the draw stages expect the visible window at H 144..783, V 35..514.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); legal values 1..16
- H_TOTAL, 800, pixel ticks per line
- H_SYNC, 96, hsync pulse width in ticks
- H_VIS_START, 144, first visible column
- H_VIS_END, 783, last visible column
- V_TOTAL, 525, lines per frame
- V_SYNC, 2, vsync pulse width in lines
- V_VIS_START, 35, first visible line
- V_VIS_END, 514, last visible line

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- horizontal_actual_position  out  16  column counter, 0..H_TOTAL-1
- vertical_actual_position  out  16  line counter, 0..V_TOTAL-1
- pixel_tick  out  1  one-clk pulse marking each pixel advance
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- video_on  out  1  high inside the visible window
- frame_start  out  1  one-clk pulse when position returns to (0,0)

Behaviour:
- Reset (async assert, sync release):
  - divider count = 0
  - positions = 0
  - pixel_tick = 0, frame_start = 0, video_on = 0
  - hsync = 0, vsync = 0 (position 0,0 lies inside both sync pulses)
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - pixel_tick is high for exactly one clk in the cycle after the divider reaches CLK_DIV-1.
  - CLK_DIV=1 gives pixel_tick constantly high after reset.
- Horizontal FSM (SYNC, BACK_PORCH, ACTIVE, FRONT_PORCH), advances only on a tick:
  - SYNC covers 0..H_SYNC-1.
  - BACK_PORCH covers H_SYNC..H_VIS_START-1.
  - ACTIVE covers H_VIS_START..H_VIS_END.
  - FRONT_PORCH covers H_VIS_END+1..H_TOTAL-1.
  - At H_TOTAL-1 the column wraps to 0 and returns to SYNC.
- Vertical FSM (same four states over V parameters):
  - Advances only on a tick where the column wraps.
  - At V_TOTAL-1 with column wrap, both counters go to 0.
- Registered outputs, updated in the same clk edge as the counters, with zero skew relative to the position outputs:
  - hsync = 0 in H SYNC state.
  - vsync = 0 in V SYNC state.
  - video_on = 1 only when both FSMs are in ACTIVE.
  - frame_start = 1 for one clk on the edge where the position becomes (0,0); it does not fire on the edge out of reset.
- Between ticks all outputs hold.
- Counter width: 16-bit, no saturation. Parameters must satisfy H_SYNC < H_VIS_START <= H_VIS_END < H_TOTAL (V likewise). Out-of-range values are not checked.
- rst_n asserted mid-frame: immediate return to reset values. First tick after release advances the column to 1.
- Downstream address (vertical*800 + horizontal) is consumer-side; this block does not compute it.

Optional Feature:
- Macro: VGA_FRAME_COUNT_EN
- Defined:
  - Adds output frame_count (16 bits).
  - Reset value 0.
  - Increments by 1 on the same edge frame_start asserts.
  - Wraps 0xFFFF -> 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, CLK_DIV=4: after rst_n release, pixel_tick pulses every 4 clks. Horizontal position reads 1 after the first tick and 799 after 799 ticks. Tick 800 gives horizontal 0, vertical 1.
- Horizontal sync window: hsync = 0 for horizontal 0..95 and 1 for 96..799. video_on rises exactly when horizontal = 144 (on a visible line) and falls at horizontal = 784.
- Vertical window: vsync = 0 for vertical 0..1, 1 for 2..524. video_on = 0 on every pixel of vertical 34 and 515, and 1 at (144,35) and (783,514).
- Frame wrap: at (799,524) the next tick gives (0,0) with frame_start high for one clk. The period between frame_start pulses is 420000 pixel ticks = 1680000 clks.
- Async reset mid-line at (400,200): hsync=0, vsync=0, video_on=0 and positions 0 are seen without waiting for a clk edge. Counting restarts cleanly and no frame_start is emitted.
- VGA_FRAME_COUNT_EN defined: frame_count reads 3 after the third frame_start. With the count forced to 0xFFFF, the next frame_start gives 0.
